// File: rtl/comb_pkg.sv
// comb_pkg: shared definitions for the binomial-coefficient sequencer.
//   N_W       operand width; equals the data width of the operand stack
//   RES_W     result width; C(15,7)=6435 is the largest result and fits
//   MAX_DEPTH bound on stack entries for any legal run
//   comb_state_t  sequencer state encoding
package comb_pkg;

  localparam int N_W       = 4;
  localparam int RES_W     = 13;
  localparam int MAX_DEPTH = 2 * (2 ** N_W);

  typedef enum logic [3:0] {
    S_IDLE,
    S_INIT_N,
    S_INIT_K,
    S_CHECK,
    S_POP_K,
    S_POP_N,
    S_EVAL,
    S_PA_N,
    S_PA_K,
    S_PB_N,
    S_PB_K,
    S_DONE
  } comb_state_t;

endpackage

// File: rtl/comb_ctrl.sv
// comb_ctrl: computes C(n,k) by walking the Pascal recursion
// C(n,k) = C(n-1,k-1) + C(n-1,k) on an external LIFO of (n,k) pairs and
// counting the leaves (k==0 or k==n). Only one pair is held locally.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   start      request pulse, honoured only in IDLE
//   n, k       operands, captured with start
//   busy       high in every state except IDLE
//   done       one-cycle pulse while result becomes valid
//   result     C(n,k), held until the next completion
//   stk_push   stack push strobe (registered, decoded from state)
//   stk_pop    stack pop strobe  (registered, decoded from state)
//   stk_din    data pushed, registered alongside the strobes
//   stk_dout   stack read data, valid the cycle after a pop
//   stk_empty  stack empty flag, combinational from the stack pointer
module comb_ctrl #(
  parameter int N_W   = comb_pkg::N_W,
  parameter int RES_W = comb_pkg::RES_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [N_W-1:0]   n,
  input  logic [N_W-1:0]   k,
  output logic             busy,
  output logic             done,
  output logic [RES_W-1:0] result,
  output logic             stk_push,
  output logic             stk_pop,
  output logic [N_W-1:0]   stk_din,
  input  logic [N_W-1:0]   stk_dout,
  input  logic             stk_empty
);
  import comb_pkg::*;

  comb_state_t      state_q;
  logic [N_W-1:0]   cur_n_q, cur_k_q;
  logic [RES_W-1:0] acc_q, result_q;
  logic             busy_q, done_q, push_q, pop_q;
  logic [N_W-1:0]   din_q;

  // Strobes are set on the transition into the state that owns them, so
  // they are high exactly while the FSM sits in that state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cur_n_q  <= '0;
      cur_k_q  <= '0;
      acc_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      push_q   <= 1'b0;
      pop_q    <= 1'b0;
      din_q    <= '0;
    end else begin
      push_q <= 1'b0;
      pop_q  <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (k > n) begin
              // Empty range: answer is zero and the stack is left alone.
              acc_q    <= '0;
              result_q <= '0;
              busy_q   <= 1'b1;
              done_q   <= 1'b1;
              state_q  <= S_DONE;
            end else if (stk_empty) begin
              cur_n_q <= n;
              cur_k_q <= k;
              acc_q   <= '0;
              busy_q  <= 1'b1;
              push_q  <= 1'b1;
              din_q   <= n;
              state_q <= S_INIT_N;
            end
          end
        end
        S_INIT_N: begin
          push_q  <= 1'b1;
          din_q   <= cur_k_q;
          state_q <= S_INIT_K;
        end
        S_INIT_K: state_q <= S_CHECK;
        S_CHECK: begin
          if (stk_empty) begin
            result_q <= acc_q;
            done_q   <= 1'b1;
            state_q  <= S_DONE;
          end else begin
            pop_q   <= 1'b1;
            state_q <= S_POP_K;
          end
        end
        S_POP_K: begin
          pop_q   <= 1'b1;
          state_q <= S_POP_N;
        end
        S_POP_N: begin
          // k (pushed last) arrives first on the registered read port.
          cur_k_q <= stk_dout;
          state_q <= S_EVAL;
        end
        S_EVAL: begin
          // n is on stk_dout now; use it directly rather than wait a cycle.
          cur_n_q <= stk_dout;
          if (cur_k_q == '0 || cur_k_q == stk_dout) begin
            acc_q   <= acc_q + 1'b1;
            state_q <= S_CHECK;
          end else begin
            push_q  <= 1'b1;
            din_q   <= stk_dout - 1'b1;
            state_q <= S_PA_N;
          end
        end
        S_PA_N: begin
          push_q  <= 1'b1;
          din_q   <= cur_k_q - 1'b1;
          state_q <= S_PA_K;
        end
        S_PA_K: begin
          push_q  <= 1'b1;
          din_q   <= cur_n_q - 1'b1;
          state_q <= S_PB_N;
        end
        S_PB_N: begin
          push_q  <= 1'b1;
          din_q   <= cur_k_q;
          state_q <= S_PB_K;
        end
        S_PB_K: state_q <= S_CHECK;
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;
  assign stk_push = push_q;
  assign stk_pop  = pop_q;
  assign stk_din  = din_q;

endmodule

// File: tb/tb_comb_ctrl.sv
module tb_comb_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  n = '0, k = '0;
  logic        busy, done;
  logic [12:0] result;
  logic        stk_push, stk_pop;
  logic [3:0]  stk_din, stk_dout;
  logic        stk_empty;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    int n; int k; int res; int lat; int pushes; int pops; int depth;
  } exp_t;
  exp_t sb_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  comb_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .n(n), .k(k),
    .busy(busy), .done(done), .result(result),
    .stk_push(stk_push), .stk_pop(stk_pop), .stk_din(stk_din),
    .stk_dout(stk_dout), .stk_empty(stk_empty)
  );

  // Behavioural LIFO: registered read data, combinational empty flag.
  logic [3:0] stk_mem [0:63];
  int sp;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      sp       <= 0;
      stk_dout <= '0;
    end else if (stk_push && sp < 64) begin
      stk_mem[sp] <= stk_din;
      sp          <= sp + 1;
    end else if (stk_pop && sp > 0) begin
      stk_dout <= stk_mem[sp-1];
      sp       <= sp - 1;
    end
  end
  assign stk_empty = (sp == 0);

  function automatic int binom(int nn, int kk);
    int r = 1;
    if (kk > nn) return 0;
    for (int i = 0; i < kk; i++) r = r * (nn - i) / (i + 1);
    return r;
  endfunction

  function automatic exp_t model(int nn, int kk);
    exp_t e;
    int c;
    c = binom(nn, kk);
    e.n = nn; e.k = kk; e.res = c;
    if (kk > nn) begin
      e.lat = 1; e.pushes = 0; e.pops = 0; e.depth = 0;
    end else begin
      // c leaves, c-1 internal nodes; root pair plus two pairs per internal.
      e.lat    = 4 + 4 * c + 8 * (c - 1);
      e.pushes = 2 + 4 * (c - 1);
      e.pops   = 2 * (2 * c - 1);
      e.depth  = 2 * (nn + 1);
    end
    return e;
  endfunction

  // Monitor: timestamps accepted starts, tracks stack traffic, and
  // compares against the scoreboard whenever done is seen.
  int st_cyc = 0, run_push = 0, run_pop = 0, run_peak = 0;
  always @(negedge clk) begin
    if (rst) begin
      if (start && !busy) begin
        st_cyc = cyc; run_push = 0; run_pop = 0; run_peak = 0;
      end
      if (stk_push) run_push++;
      if (stk_pop)  run_pop++;
      if (sp > run_peak) run_peak = sp;
      if (stk_push || stk_pop) begin
        checks++;
        if (stk_push && stk_pop) begin
          errors++; $display("FAIL proto_push_pop cyc=%0d both strobes high", cyc);
        end else if (stk_pop && stk_empty) begin
          errors++; $display("FAIL proto_pop_empty cyc=%0d pop while empty", cyc);
        end
      end
      if (done) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++; $display("FAIL unexpected_done cyc=%0d result=%0d", cyc, result);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          if (result !== 13'(e.res)) begin
            errors++; $display("FAIL result(%0d,%0d) got=%0d exp=%0d", e.n, e.k, result, e.res);
          end
          checks++;
          if (cyc - st_cyc != e.lat) begin
            errors++; $display("FAIL latency(%0d,%0d) got=%0d exp=%0d", e.n, e.k, cyc - st_cyc, e.lat);
          end
          checks++;
          if (run_push != e.pushes || run_pop != e.pops) begin
            errors++; $display("FAIL stack_ops(%0d,%0d) push=%0d pop=%0d exp push=%0d pop=%0d",
                               e.n, e.k, run_push, run_pop, e.pushes, e.pops);
          end
          checks++;
          if (run_peak > e.depth || run_peak > comb_pkg::MAX_DEPTH) begin
            errors++; $display("FAIL peak_depth(%0d,%0d) got=%0d max=%0d", e.n, e.k, run_peak, e.depth);
          end
          checks++;
          if (!stk_empty || !busy) begin
            errors++; $display("FAIL done_state(%0d,%0d) empty=%0b busy=%0b exp empty=1 busy=1",
                               e.n, e.k, stk_empty, busy);
          end
        end
      end
    end
  end

  task automatic pulse_start(int nn, int kk);
    @(posedge clk); #1;
    start = 1'b1; n = 4'(nn); k = 4'(kk);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Issue one request; optionally poke start again while busy.
  task automatic issue(int nn, int kk, bit poke);
    exp_t e;
    bit fin;
    e = model(nn, kk);
    sb_q.push_back(e);
    pulse_start(nn, kk);
    fin = 1'b0;
    for (int i = 0; i < e.lat + 20; i++) begin
      if (poke && i == 5) begin start = 1'b1; n = 4'd3; k = 4'd1; end
      if (poke && i == 6) start = 1'b0;
      if (!busy) begin fin = 1'b1; break; end
      @(posedge clk); #1;
    end
    checks++;
    if (!fin) begin
      errors++; $display("FAIL timeout(%0d,%0d) busy=%0b after %0d cycles", nn, kk, busy, e.lat + 20);
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic check_reset_outputs(string tag);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== '0 ||
        stk_push !== 1'b0 || stk_pop !== 1'b0 || stk_din !== '0) begin
      errors++;
      $display("FAIL %s busy=%0b done=%0b result=%0d push=%0b pop=%0b din=%0d exp all 0",
               tag, busy, done, result, stk_push, stk_pop, stk_din);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    check_reset_outputs("reset_values");
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);

    issue(0, 0, 1'b0);
    issue(4, 2, 1'b0);
    issue(3, 5, 1'b0);
    issue(5, 2, 1'b1);   // start pulse while busy must be ignored

    // Abort a run mid-flight; no expectation is queued for it.
    pulse_start(6, 3);
    repeat (40) @(posedge clk);
    #1 rst = 1'b0;
    #1 check_reset_outputs("mid_run_reset");
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    issue(5, 5, 1'b0);

    for (int t = 0; t < 12; t++)
      issue(int'($urandom_range(0, 7)), int'($urandom_range(0, 8)), 1'b0);

    issue(15, 7, 1'b0);

    checks++;
    if (sb_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain left=%0d exp=0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
